// File: rtl/vram_fill_ctrl.sv
// Rectangle tile-fill engine with per-tile read-modify-write, sharing VRAM port 1 with the CPU.
// Optional macro VRAM_FILL_VBLANK_EN restricts engine VRAM accesses to vertical blanking.
module vram_fill_ctrl #(
  parameter int unsigned TILES_H = 28,
  parameter int unsigned TILES_V = 18,
  parameter int unsigned ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wenable,
  output logic [7:0]        cpu_rdata,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_x,
  input  logic [4:0]        cmd_y,
  input  logic [4:0]        cmd_w,
  input  logic [4:0]        cmd_h,
  input  logic [1:0]        cmd_color,
  input  logic              vblank,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_wenable,
  input  logic [7:0]        vram_rdata
);

  localparam int unsigned TileW = $clog2(TILES_H * TILES_V);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRd   = 3'd1;
  localparam logic [2:0] StMod  = 3'd2;
  localparam logic [2:0] StWr   = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [4:0]        org_x_q, x_end_q, y_end_q, cur_x_q, cur_y_q;
  logic [1:0]        color_q;
  logic [7:0]        byte_q;
  logic              blocked;
  logic [5:0]        x_sum, y_sum;
  logic [4:0]        x_clip, y_clip;
  logic              cmd_empty;
  logic [TileW-1:0]  tile_idx;
  logic [ADDR_W-1:0] eng_addr;
  logic [7:0]        mod_byte;
  logic              last_x, last_y;
  logic              eng_active;

`ifdef VRAM_FILL_VBLANK_EN
  assign blocked = cpu_req | ~vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign blocked = cpu_req;
`endif

  always_comb begin
    x_sum     = {1'b0, cmd_x} + {1'b0, cmd_w};
    y_sum     = {1'b0, cmd_y} + {1'b0, cmd_h};
    x_clip    = (x_sum > 6'(TILES_H)) ? 5'(TILES_H) : x_sum[4:0];
    y_clip    = (y_sum > 6'(TILES_V)) ? 5'(TILES_V) : y_sum[4:0];
    cmd_empty = (cmd_w == 5'd0) || (cmd_h == 5'd0) ||
                (cmd_x >= 5'(TILES_H)) || (cmd_y >= 5'(TILES_V));
  end

  assign tile_idx = TileW'(cur_y_q) * TileW'(TILES_H) + TileW'(cur_x_q);
  assign eng_addr = ADDR_W'(tile_idx >> 2);
  assign last_x   = (cur_x_q + 5'd1) == x_end_q;
  assign last_y   = (cur_y_q + 5'd1) == y_end_q;

  // Splice the colour into the freshly read byte; other tiles keep their current value.
  always_comb begin
    mod_byte = vram_rdata;
    mod_byte[{tile_idx[1:0], 1'b0} +: 2] = color_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (cmd_valid) state_d = cmd_empty ? StDone : StRd;
      StRd:   if (!blocked) state_d = StMod;
      StMod:  state_d = blocked ? StRd : StWr;
      StWr:   if (!blocked) state_d = (last_x && last_y) ? StDone : StRd;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      org_x_q <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      color_q <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && cmd_valid) begin
        org_x_q <= cmd_x;
        cur_x_q <= cmd_x;
        cur_y_q <= cmd_y;
        x_end_q <= x_clip;
        y_end_q <= y_clip;
        color_q <= cmd_color;
      end
      if (state_q == StMod && !blocked) byte_q <= mod_byte;
      if (state_q == StWr && !blocked) begin
        if (last_x) begin
          cur_x_q <= org_x_q;
          cur_y_q <= cur_y_q + 5'd1;
        end else begin
          cur_x_q <= cur_x_q + 5'd1;
        end
      end
    end
  end

  assign eng_active = (state_q == StRd) || (state_q == StMod) || (state_q == StWr);

  // CPU always wins the port; the engine simply stalls while blocked.
  always_comb begin
    if (cpu_req) begin
      vram_addr    = cpu_addr;
      vram_wdata   = cpu_wdata;
      vram_wenable = cpu_wenable;
    end else begin
      vram_addr    = eng_active ? eng_addr : '0;
      vram_wdata   = (state_q == StWr) ? byte_q : '0;
      vram_wenable = (state_q == StWr) && !blocked;
    end
  end

  assign cpu_rdata = vram_rdata;
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Bench for vram_fill_ctrl: VRAM memory model, directed scenarios and randomized commands checked
// against a tile-array reference of the expected VRAM image and fill latency.
module tb_vram_fill_ctrl;

  localparam int TH = 28;
  localparam int TV = 18;
  localparam int AW = 7;

`ifdef VRAM_FILL_VBLANK_EN
  localparam bit VbGates = 1'b1;
`else
  localparam bit VbGates = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          cpu_wenable;
  logic [7:0]    cpu_rdata;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [4:0]    cmd_x, cmd_y, cmd_w, cmd_h;
  logic [1:0]    cmd_color;
  logic          vblank;
  logic          busy;
  logic          done;
  logic [AW-1:0] vram_addr;
  logic [7:0]    vram_wdata;
  logic          vram_wenable;
  logic [7:0]    vram_rdata;

  always #5 clk = ~clk;

  vram_fill_ctrl #(.TILES_H(TH), .TILES_V(TV), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wenable(cpu_wenable), .cpu_rdata(cpu_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .vblank(vblank), .busy(busy), .done(done),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_wenable(vram_wenable),
    .vram_rdata(vram_rdata)
  );

  // Video-unit VRAM port: synchronous read, write on wenable.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (vram_wenable) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  logic [7:0] exp_mem [128];
  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int t, input int c);
    logic [1:0] cv;
    cv = 2'(c);
    exp_mem[t / 4][2 * (t % 4) +: 2] = cv;
  endtask

  task automatic cmp_mem(input string tag);
    for (int b = 0; b < 128; b++) chk($sformatf("%s byte%0d", tag, b), mem[b], exp_mem[b]);
  endtask

  // hit > 0: CPU writes byte 0 = 0 in that cycle after accept (accept cycle = 0).
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                         input bit noisy, input int hit);
    int lat, nwr, n, xe, ye;
    xe = (x + w > TH) ? TH : x + w;
    ye = (y + h > TV) ? TV : y + h;
    n  = (w == 0 || h == 0 || x >= TH || y >= TV) ? 0 : (xe - x) * (ye - y);
    cmd_x = 5'(x); cmd_y = 5'(y); cmd_w = 5'(w); cmd_h = 5'(h); cmd_color = 2'(c);
    cmd_valid = 1'b1; cpu_req = 1'b0; cpu_wenable = 1'b0;
    vblank = VbGates ? 1'b1 : 1'($urandom_range(0, 1));
    #1;
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_x = 5'($urandom); cmd_y = 5'($urandom); cmd_w = 5'($urandom); cmd_h = 5'($urandom);
    cmd_color = 2'($urandom);
    lat = 1; nwr = 0;
    while (!done && lat < 6000) begin
      cpu_req = 1'b0; cpu_wenable = 1'b0;
      if (noisy) begin
        cpu_req  = ($urandom_range(0, 3) == 0);
        cpu_addr = 7'($urandom_range(0, 127));
        cpu_wdata = 8'($urandom);
        vblank   = ($urandom_range(0, 3) != 0);
      end
      if (lat == hit) begin
        cpu_req = 1'b1; cpu_wenable = 1'b1; cpu_addr = '0; cpu_wdata = 8'h00;
        exp_mem[0] = 8'h00;
      end
      #1;
      if (cpu_req) begin
        chk("mux_addr", vram_addr, cpu_addr);
        chk("mux_we", vram_wenable, cpu_wenable);
      end else if (vram_wenable) begin
        nwr++;
      end
      @(posedge clk); #1;
      lat++;
    end
    cpu_req = 1'b0; cpu_wenable = 1'b0;
    chk("done_seen", done, 1);
    if (!noisy) chk($sformatf("latency n=%0d", n), lat, (hit > 0) ? 3 * n + 3 : 3 * n + 1);
    chk("engine_writes", nwr, n);
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++) set_tile(yy * TH + xx, c);
    cmp_mem("fill");
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
  endtask

`ifdef VRAM_FILL_VBLANK_EN
  task automatic vblank_test();
    int nwr, lat;
    vblank = 1'b0;
    cmd_x = 5'd3; cmd_y = 5'd2; cmd_w = 5'd2; cmd_h = 5'd1; cmd_color = 2'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    nwr = 0;
    repeat (100) begin
      if (vram_wenable) nwr++;
      @(posedge clk); #1;
    end
    chk("vb_stall_writes", nwr, 0);
    chk("vb_stall_busy", busy, 1);
    vblank = 1'b1;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("vb_done", done, 1);
    set_tile(2 * TH + 3, 2);
    set_tile(2 * TH + 4, 2);
    cmp_mem("vblank");
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    logic [7:0] v;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wenable = 1'b0;
    cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    vblank = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_we", vram_wenable, 0);
    chk("rst_addr", vram_addr, 0);
    chk("rst_wdata", vram_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Preload through the CPU port.
    for (int b = 0; b < 128; b++) begin
      v = (b == 0) ? 8'hFF : 8'($urandom);
      cpu_req = 1'b1; cpu_wenable = 1'b1; cpu_addr = 7'(b); cpu_wdata = v;
      exp_mem[b] = v;
      @(posedge clk); #1;
    end
    cpu_wenable = 1'b0; cpu_addr = 7'd5;
    @(posedge clk); #1;
    chk("cpu_rdata", cpu_rdata, exp_mem[5]);
    cpu_req = 1'b0;

    run_cmd(1, 0, 1, 1, 0, 1'b0, -1);
    chk("single_tile_byte0", mem[0], 8'hF3);
    run_cmd(26, 17, 5, 5, 2, 1'b0, -1);
    v = mem[125];
    chk("clip_byte125_hi", v[7:4], 4'hA);
    run_cmd(0, 0, 0, 3, 1, 1'b0, -1);
    run_cmd(29, 2, 3, 3, 1, 1'b0, -1);
    run_cmd(0, 0, 1, 1, 3, 1'b0, 2);
    chk("reread_byte0", mem[0], 8'h03);

    // Reset during the first WR of a 10-tile fill.
    cmd_x = 5'd0; cmd_y = 5'd5; cmd_w = 5'd10; cmd_h = 5'd1; cmd_color = 2'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_wr", vram_wenable, 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_we", vram_wenable, 0);
    @(posedge clk); #1;
    chk("abort_no_done", done, 0);
    rst = 1'b0;
    cmp_mem("abort");
    run_cmd(4, 6, 3, 2, 2, 1'b0, -1);

`ifdef VRAM_FILL_VBLANK_EN
    vblank_test();
`endif

    for (int i = 0; i < 24; i++) begin
      run_cmd(int'($urandom_range(0, 31)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), 1'(i % 2), -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
